// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes an RV32I ALU instruction into {a, b, ctl, rd, illegal}
// and presents it through a registered valid/ready output with a one-entry skid slot.
module alu_issue_stage #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_rs1_data,
    input  logic [DATA_WIDTH-1:0] in_rs2_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_a,
    output logic [DATA_WIDTH-1:0] out_b,
    output logic [3:0]            out_ctl,
    output logic [4:0]            out_rd,
    output logic                  out_illegal
);

    localparam logic [3:0] CtlAnd = 4'd0;
    localparam logic [3:0] CtlOr  = 4'd1;
    localparam logic [3:0] CtlXor = 4'd2;
    localparam logic [3:0] CtlAdd = 4'd3;
    localparam logic [3:0] CtlSub = 4'd4;
    localparam logic [3:0] CtlSll = 4'd5;
    localparam logic [3:0] CtlSrl = 4'd6;
    localparam logic [3:0] CtlSra = 4'd7;
    localparam logic [3:0] CtlSlt = 4'd8;

    localparam logic [6:0] OpReg   = 7'b0110011;
    localparam logic [6:0] OpImm   = 7'b0010011;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [3:0]            ctl;
        logic [4:0]            rd;
        logic                  illegal;
    } entry_t;

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e state_q, state_d;
    entry_t out_q, out_d, skid_q, skid_d;
    entry_t dec_entry;

    logic [DATA_WIDTH-1:0] imm_i, imm_u, shamt_rs2, shamt_imm;
    logic [DATA_WIDTH-1:0] dec_a, dec_b;
    logic [3:0]            dec_ctl;
    logic                  dec_illegal;
    logic [2:0]            f3;
    logic                  f7_zero, f7_alt;
    logic                  accept, drain;
    logic                  load_out, out_from_skid, load_skid;

    assign f3        = in_instr[14:12];
    assign f7_zero   = (in_instr[31:25] == 7'b0000000);
    assign f7_alt    = (in_instr[31:25] == 7'b0100000);
    assign imm_i     = DATA_WIDTH'($signed(in_instr[31:20]));
    assign imm_u     = DATA_WIDTH'($signed({in_instr[31:12], 12'b0}));
    assign shamt_rs2 = DATA_WIDTH'(in_rs2_data[4:0]);
    assign shamt_imm = DATA_WIDTH'(in_instr[24:20]);

    // Instruction decode and operand selection for the incoming instruction
    always_comb begin
        dec_a       = in_rs1_data;
        dec_b       = in_rs2_data;
        dec_ctl     = CtlAdd;
        dec_illegal = 1'b0;
        case (in_instr[6:0])
            OpReg: begin
                case (f3)
                    3'b000: begin
                        dec_ctl     = f7_alt ? CtlSub : CtlAdd;
                        dec_illegal = !(f7_zero || f7_alt);
                    end
                    3'b001: begin
                        dec_ctl     = CtlSll;
                        dec_b       = shamt_rs2;
                        dec_illegal = !f7_zero;
                    end
                    3'b010: begin dec_ctl = CtlSlt; dec_illegal = !f7_zero; end
                    3'b011: dec_illegal = 1'b1;
                    3'b100: begin dec_ctl = CtlXor; dec_illegal = !f7_zero; end
                    3'b101: begin
                        dec_ctl     = f7_alt ? CtlSra : CtlSrl;
                        dec_b       = shamt_rs2;
                        dec_illegal = !(f7_zero || f7_alt);
                    end
                    3'b110: begin dec_ctl = CtlOr;  dec_illegal = !f7_zero; end
                    default: begin dec_ctl = CtlAnd; dec_illegal = !f7_zero; end
                endcase
            end
            OpImm: begin
                dec_b = imm_i;
                case (f3)
                    3'b000: dec_ctl = CtlAdd;
                    3'b001: begin
                        dec_ctl     = CtlSll;
                        dec_b       = shamt_imm;
                        dec_illegal = !f7_zero;
                    end
                    3'b010: dec_ctl = CtlSlt;
                    3'b011: dec_illegal = 1'b1;
                    3'b100: dec_ctl = CtlXor;
                    3'b101: begin
                        dec_ctl     = f7_alt ? CtlSra : CtlSrl;
                        dec_b       = shamt_imm;
                        dec_illegal = !(f7_zero || f7_alt);
                    end
                    3'b110: dec_ctl = CtlOr;
                    default: dec_ctl = CtlAnd;
                endcase
            end
            OpLui: begin
                dec_a = '0;
                dec_b = imm_u;
            end
            OpAuipc: begin
                dec_a = in_pc;
                dec_b = imm_u;
            end
            default: dec_illegal = 1'b1;
        endcase
        // Illegal entries still flow in order but carry neutral operands
        if (dec_illegal) begin
            dec_a   = '0;
            dec_b   = '0;
            dec_ctl = CtlAdd;
        end
    end

    assign dec_entry = '{a: dec_a, b: dec_b, ctl: dec_ctl, rd: in_instr[11:7],
                         illegal: dec_illegal};

    assign accept = in_valid && in_ready && !flush;
    assign drain  = out_valid && out_ready;

    // Buffer occupancy state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StEmpty;
        else     state_q <= state_d;
    end

    // Occupancy next state; flush wins over accept and drain
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: if (accept) state_d = StOne;
                StOne: begin
                    if (accept && !drain)      state_d = StFull;
                    else if (!accept && drain) state_d = StEmpty;
                end
                StFull:  if (drain) state_d = StOne;
                default: state_d = StEmpty;
            endcase
        end
    end

    // Handshake outputs and datapath load enables decoded from occupancy
    always_comb begin
        out_valid     = (state_q != StEmpty);
        in_ready      = (state_q != StFull);
        out_from_skid = (state_q == StFull);
        load_out      = !flush && (((state_q == StEmpty) && accept) ||
                                   ((state_q == StOne) && accept && drain) ||
                                   ((state_q == StFull) && drain));
        load_skid     = !flush && (state_q == StOne) && accept && !drain;
    end

    // Next contents of the output register and skid slot
    always_comb begin
        out_d  = out_q;
        skid_d = skid_q;
        if (load_out)  out_d  = out_from_skid ? skid_q : dec_entry;
        if (load_skid) skid_d = dec_entry;
    end

    // Output register and skid slot storage
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            out_q  <= out_d;
            skid_q <= skid_d;
        end
    end

    assign out_a       = out_q.a;
    assign out_b       = out_q.b;
    assign out_ctl     = out_q.ctl;
    assign out_rd      = out_q.rd;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed decode, backpressure, flush,
// reset, and randomized traffic against a queue-based reference model.
module tb_alu_issue_stage;

    typedef struct packed {
        logic        valid;
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data, out_a, out_b;
    logic [3:0]  out_ctl;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int vectors = 0;
    int errors  = 0;

    // ALU code by funct3 for register/immediate ops; +1 selects SUB/SRA
    int ctl_tab [8] = '{3, 5, 8, 0, 2, 6, 1, 0};

    alu_issue_stage #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .out_ctl(out_ctl), .out_rd(out_rd), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t obs();
        return '{valid: out_valid, ctl: out_ctl, a: out_a, b: out_b, rd: out_rd,
                 ill: out_illegal};
    endfunction

    function automatic exp_t mk(logic [3:0] ctl, logic [31:0] a, logic [31:0] b,
                                logic [4:0] rd, logic ill);
        return '{valid: 1'b1, ctl: ctl, a: a, b: b, rd: rd, ill: ill};
    endfunction

    function automatic exp_t ref_decode(logic [31:0] ins, logic [31:0] pc,
                                        logic [31:0] rs1, logic [31:0] rs2);
        exp_t e;
        int f3, f7;
        bit legal, shift;
        logic [31:0] imm_i, imm_u;
        f3    = int'(ins[14:12]);
        f7    = int'(ins[31:25]);
        shift = (f3 == 1) || (f3 == 5);
        imm_i = {{20{ins[31]}}, ins[31:20]};
        imm_u = ins & 32'hFFFF_F000;
        e = '{valid: 1'b1, ctl: 4'd3, a: 32'd0, b: 32'd0, rd: ins[11:7], ill: 1'b0};
        legal = 1'b1;
        if (ins[6:0] == 7'h33) begin
            legal = (f7 == 0 && f3 != 3) || (f7 == 32 && (f3 == 0 || f3 == 5));
            e.a   = rs1;
            e.b   = shift ? (rs2 % 32) : rs2;
            e.ctl = 4'(ctl_tab[f3] + ((f7 == 32) ? 1 : 0));
        end else if (ins[6:0] == 7'h13) begin
            legal = (f3 != 3) && (!shift || f7 == 0 || (f3 == 5 && f7 == 32));
            e.a   = rs1;
            e.b   = shift ? {27'd0, ins[24:20]} : imm_i;
            e.ctl = 4'(ctl_tab[f3] + ((f3 == 5 && f7 == 32) ? 1 : 0));
        end else if (ins[6:0] == 7'h37) begin
            e.b = imm_u;
        end else if (ins[6:0] == 7'h17) begin
            e.a = pc;
            e.b = imm_u;
        end else begin
            legal = 1'b0;
        end
        if (!legal) begin
            e.ctl = 4'd3; e.a = 32'd0; e.b = 32'd0; e.ill = 1'b1;
        end
        return e;
    endfunction

    task automatic drive(logic v, logic [31:0] ins, logic [31:0] pc,
                         logic [31:0] rs1, logic [31:0] rs2);
        in_valid = v; in_instr = ins; in_pc = pc; in_rs1_data = rs1; in_rs2_data = rs2;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        vectors++;
        if ({obs(), in_ready} !== {exp_t'(0), 1'b1}) begin
            errors++;
            $display("FAIL reset: got %h rdy %b, want all-zero rdy 1", obs(), in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reset_idle: got v%b r%b, want v0 r1", out_valid, in_ready);
        end
    endtask

    task automatic test_decode();
        logic [31:0] ins [11] = '{32'h002081B3, 32'h402081B3, 32'h40335293, 32'h123450B7,
                                  32'h12345097, 32'h0020B1B3, 32'h0000007F, 32'hFFF08113,
                                  32'h002091B3, 32'h0020A1B3, 32'h4020C1B3};
        logic [31:0] pcs [11] = '{0, 0, 0, 0, 32'h100, 0, 0, 0, 0, 0, 0};
        logic [31:0] r1  [11] = '{5, 5, 32'h8000_0000, 9, 9, 9, 9, 1, 1, 3, 3};
        logic [31:0] r2  [11] = '{7, 7, 0, 9, 9, 11, 11, 0, 32'h25, 4, 4};
        exp_t ex [11];
        ex[0]  = mk(4'd3, 5, 7, 5'd3, 1'b0);
        ex[1]  = mk(4'd4, 5, 7, 5'd3, 1'b0);
        ex[2]  = mk(4'd7, 32'h8000_0000, 3, 5'd5, 1'b0);
        ex[3]  = mk(4'd3, 0, 32'h1234_5000, 5'd1, 1'b0);
        ex[4]  = mk(4'd3, 32'h100, 32'h1234_5000, 5'd1, 1'b0);
        ex[5]  = mk(4'd3, 0, 0, 5'd3, 1'b1);
        ex[6]  = mk(4'd3, 0, 0, 5'd0, 1'b1);
        ex[7]  = mk(4'd3, 1, 32'hFFFF_FFFF, 5'd2, 1'b0);
        ex[8]  = mk(4'd5, 1, 5, 5'd3, 1'b0);
        ex[9]  = mk(4'd8, 3, 4, 5'd3, 1'b0);
        ex[10] = mk(4'd3, 0, 0, 5'd3, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i <= 11; i++) begin
            @(negedge clk);
            if (i > 0) begin
                vectors++;
                if (obs() !== ex[i-1]) begin
                    errors++;
                    $display("FAIL decode[%0d]: got %h want %h", i - 1, obs(), ex[i-1]);
                end
            end
            if (i < 11) drive(1'b1, ins[i], pcs[i], r1[i], r2[i]);
            else        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        end
    endtask

    task automatic test_backpressure();
        exp_t e_add, e_xor, e_or;
        e_add = mk(4'd3, 5, 7, 5'd3, 1'b0);
        e_xor = mk(4'd2, 32'hF0, 32'h0F, 5'd4, 1'b0);
        e_or  = mk(4'd1, 32'h11, 32'h22, 5'd5, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 0, 5, 7);
        @(negedge clk);
        vectors++;
        if ({obs(), in_ready} !== {e_add, 1'b1}) begin
            errors++;
            $display("FAIL bp_c1: got %h rdy %b want %h rdy 1", obs(), in_ready, e_add);
        end
        drive(1'b1, 32'h0020C233, 0, 32'hF0, 32'h0F);
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk);
            vectors++;
            if ({obs(), in_ready} !== {e_add, 1'b0}) begin
                errors++;
                $display("FAIL bp_stall%0d: got %h rdy %b want %h rdy 0", c, obs(), in_ready,
                         e_add);
            end
            drive(1'b1, 32'h0020E2B3, 0, 32'h11, 32'h22);
        end
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({obs(), in_ready} !== {e_xor, 1'b1}) begin
            errors++;
            $display("FAIL bp_xor: got %h rdy %b want %h rdy 1", obs(), in_ready, e_xor);
        end
        @(negedge clk);
        vectors++;
        if (obs() !== e_or) begin
            errors++;
            $display("FAIL bp_or: got %h want %h", obs(), e_or);
        end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: got v%b want v0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        @(negedge clk) drive(1'b1, 32'h002081B3, 0, 1, 2);
        @(negedge clk) drive(1'b1, 32'h402081B3, 0, 3, 4);
        @(negedge clk);
        vectors++;
        if ({out_valid, in_ready} !== 2'b10) begin
            errors++;
            $display("FAIL flush_full: got v%b r%b want v1 r0", out_valid, in_ready);
        end
        flush = 1'b1;
        drive(1'b1, 32'hABCDE3B7, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL flush_next: got v%b r%b want v0 r1", out_valid, in_ready);
        end
        flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_drop%0d: got v%b want v0", c, out_valid);
            end
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        @(negedge clk) drive(1'b1, 32'h12345097, 32'h100, 1, 2);
        @(negedge clk) drive(1'b1, 32'h002081B3, 0, 5, 7);
        @(negedge clk);
        rst = 1'b1; flush = 1'b1;
        drive(1'b1, 32'h0020C233, 0, 1, 1);
        @(negedge clk);
        vectors++;
        if ({obs(), in_ready} !== {exp_t'(0), 1'b1}) begin
            errors++;
            $display("FAIL rst_mid: got %h rdy %b want all-zero rdy 1", obs(), in_ready);
        end
        rst = 1'b0; flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_hold: got v%b want v0", out_valid);
        end
    endtask

    task automatic test_random();
        exp_t q[$];
        logic [31:0] ins;
        logic [6:0] opc;
        bit acc, drn;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            vectors++;
            if ({out_valid, in_ready} !== {q.size() > 0, q.size() < 2}) begin
                errors++;
                $display("FAIL rand_hs@%0d: got v%b r%b want v%b r%b", cyc, out_valid,
                         in_ready, q.size() > 0, q.size() < 2);
            end
            if (q.size() > 0) begin
                vectors++;
                if (obs() !== q[0]) begin
                    errors++;
                    $display("FAIL rand_data@%0d: got %h want %h", cyc, obs(), q[0]);
                end
            end
            case ($urandom_range(0, 9))
                0, 1, 2, 3: opc = 7'h33;
                4, 5, 6:    opc = 7'h13;
                7:          opc = 7'h37;
                8:          opc = 7'h17;
                default:    opc = 7'($urandom);
            endcase
            ins = $urandom;
            ins[6:0] = opc;
            case ($urandom_range(0, 3))
                0, 1:    ins[31:25] = 7'h00;
                2:       ins[31:25] = 7'h20;
                default: ;
            endcase
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            drive($urandom_range(0, 3) != 0, ins, $urandom, $urandom, $urandom);
            acc = in_valid && (q.size() < 2) && !flush;
            drn = (q.size() > 0) && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (drn) void'(q.pop_front());
                if (acc) q.push_back(ref_decode(in_instr, in_pc, in_rs1_data, in_rs2_data));
            end
        end
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Registered decode/issue stage that generates the ALU control interface: a, b, and the 4-bit ctl code.
- Decodes an RV32I instruction into ALU ctl, selects the operands, and presents them through a valid/ready output with a 2-entry skid buffer.
- Sits between register-file read and the combinational ALU, and forms the ID/EX boundary.

Parameters:
DATA_WIDTH, 32, operand/PC width (spec values assume 32)

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  drop all buffered entries (branch/trap redirect)
in_valid  input  1  instruction and operands valid
in_ready  output  1  stage can accept this cycle
in_instr  input  32  instruction word
in_pc  input  DATA_WIDTH  instruction PC
in_rs1_data  input  DATA_WIDTH  rs1 read value
in_rs2_data  input  DATA_WIDTH  rs2 read value
out_valid  output  1  issue entry valid
out_ready  input  1  ALU/EX stage accepts entry
out_a  output  DATA_WIDTH  ALU operand a
out_b  output  DATA_WIDTH  ALU operand b
out_ctl  output  4  ALU op: 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 SLL, 6 SRL, 7 SRA, 8 SLT
out_rd  output  5  destination register (instr[11:7])
out_illegal  output  1  instruction not executable on this ALU

Behaviour:
- Reset: clk and rst only, synchronous and active-high. Reset values: out_valid=0, skid entry empty, in_ready=1 from the first cycle after reset; out_a/out_b/out_ctl/out_rd/out_illegal=0.
- Decode by opcode (instr[6:0]), with f3=instr[14:12] and f7=instr[31:25]:
  - OP 0110011: a=rs1, b=rs2.
    - f3 000: ADD if f7=0000000, SUB if f7=0100000.
    - f3 100 XOR, 110 OR, 111 AND, 010 SLT, 001 SLL, 101 SRL (f7=0) / SRA (f7=0100000).
    - f3 011 (SLTU) is illegal.
    - f7 0100000 is legal only with f3 000/101; any other f7 is illegal.
    - For shifts, b = {27'b0, rs2[4:0]}.
  - OP-IMM 0010011: a=rs1, b=sign-extended instr[31:20].
    - f3 000 ADD, 100 XOR, 110 OR, 111 AND, 010 SLT.
    - f3 011 (SLTIU) is illegal.
    - f3 001 SLL requires f7=0. f3 101 requires f7=0 (SRL) or 0100000 (SRA). Any other f7 is illegal.
    - For shifts, b = {27'b0, instr[24:20]}.
  - LUI 0110111: a=0, b={instr[31:12],12'b0}, ctl=ADD.
  - AUIPC 0010111: a=pc, b={instr[31:12],12'b0}, ctl=ADD.
  - Any other opcode is illegal.
- Illegal entries still issue in order with out_illegal=1, ctl=3, a=0, b=0, rd=instr[11:7].
- Handshake and transfer:
  - Input transfer: in_valid&&in_ready. Output transfer: out_valid&&out_ready.
  - Latency: an accepted instruction appears on out_* the next cycle when the output register is empty or is draining that cycle.
  - out_* are driven directly from the output register, with no combinational path from in_* to out_*.
  - in_ready is a registered signal equal to !skid_valid, with no combinational path from out_ready.
- Buffer states:
  - EMPTY: out_valid=0, skid=0.
  - ONE: out_valid=1, skid=0.
  - FULL: out_valid=1, skid=1, in_ready=0.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept + no drain -> FULL, with the new entry stored in skid.
  - ONE + accept + drain -> ONE with the new entry.
  - ONE + drain only -> EMPTY.
  - FULL + drain -> ONE, with skid moved to the output register.
  - A FULL state never sees an accept.
- Order: entries leave strictly in acceptance order, with no loss and no duplication.
- out_* hold stable while out_valid=1 and out_ready=0.
- flush: next cycle out_valid=0, skid empty, in_ready=1. An input presented in the flush cycle is discarded even if in_ready=1. flush has priority over accept and drain.
- rst has priority over flush.
- When in_valid=0, the in_* data inputs are don't-care and no state changes.

Test Plan:
- ADD x3,x1,x2 in_instr=0x002081B3, rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, ctl=3, a=5, b=7, rd=3, illegal=0.
- SUB 0x402081B3 with rs1=5, rs2=7 -> ctl=4, a=5, b=7. SRAI x5,x6,3 0x40335293 with rs1=0x80000000 -> ctl=7, b=3, rd=5.
- LUI x1,0x12345 0x123450B7 -> ctl=3, a=0, b=0x12345000. AUIPC 0x12345097 with pc=0x100 -> a=0x100, b=0x12345000.
- SLTU 0x0020B1B3 and opcode 0x0000007F -> out_illegal=1, ctl=3, a=0, b=0, issued in order with neighbours.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 and ADD/XOR/OR back-to-back -> two accepted, in_ready=0 from cycle 2. After release, the outputs are ADD, XOR, OR in order, and out_* are stable while stalled.
- FULL state then flush=1 with in_valid=1 -> next cycle out_valid=0 and in_ready=1, and the flush-cycle input never appears. rst mid-stream -> out_valid=0 and all outputs 0.
